l2_min_select: RTL and testbench

Consumer end of the L2 distance datapath. It accepts a stream of FP16 (IEEE half) distance values, one per candidate, for a single query. It tracks the running minimum and its candidate index, then presents the nearest-neighbour result with a valid/ready handshake. It sits downstream of the per-candidate l2Dis distance units and turns their distance words into a single query answer.

---
 rtl/l2_min_select.sv | 177 +++++++++++++++++
 tb/tb_l2_min_select.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_min_select.sv
// l2_min_select: nearest-neighbour reduction over a frame of FP16 distances.
//
// Accepts one FP16 distance per candidate, keeps the running minimum by
// magnitude (bits [14:0]) together with its arrival index, and presents the
// frame result through a valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   distance beat valid
//   in_ready   block can accept a beat (SCAN state, not in reset)
//   in_dist    FP16 distance of the current candidate
//   in_last    final candidate of the frame
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts the result
//   out_min    minimum distance magnitude (sign bit always 0), 7E00 if all NaN
//   out_idx    0-based arrival index of the minimum
//   out_count  number of beats in the frame
//   out_nan    at least one NaN beat in the frame
//   out_neg    at least one negative non-zero beat in the frame
//
// state | meaning
// SCAN  | accepting beats, updating running minimum
// DONE  | result presented, waiting for out_ready
module l2_min_select #(
  parameter int N_CAND = 7,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_dist,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_min,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_nan,
  output logic             out_neg
);

  typedef enum logic {SCAN, DONE} state_e;

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N_CAND);
  localparam logic [15:0]    QNAN    = 16'h7E00;

  state_e           state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [14:0]      run_min_q, run_min_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic             have_q, have_d;
  logic             nan_q, nan_d;
  logic             neg_q, neg_d;

  logic [15:0]      res_min_q, res_min_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [IDX_W:0]   res_cnt_q, res_cnt_d;
  logic             res_nan_q, res_nan_d;
  logic             res_neg_q, res_neg_d;

  logic             accept;
  logic             close;
  logic [14:0]      beat_mag;
  logic             beat_nan;
  logic             beat_neg;
  logic             beat_take;
  logic [IDX_W:0]   cnt_inc;
  logic [14:0]      mrg_min;
  logic [IDX_W-1:0] mrg_idx;
  logic             mrg_have;
  logic             mrg_nan;
  logic             mrg_neg;

  assign in_ready  = (state_q == SCAN) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_min   = res_min_q;
  assign out_idx   = res_idx_q;
  assign out_count = res_cnt_q;
  assign out_nan   = res_nan_q;
  assign out_neg   = res_neg_q;

  assign accept   = in_valid && in_ready;
  assign beat_mag = in_dist[14:0];
  assign beat_nan = (&in_dist[14:10]) && (|in_dist[9:0]);
  assign beat_neg = in_dist[15] && (|beat_mag);
  assign cnt_inc  = cnt_q + (IDX_W+1)'(1);
  // in_last on the N_CAND-th beat collapses into the same single close
  assign close    = accept && (in_last || (cnt_inc == CNT_MAX));

  // strictly-less keeps the earliest index on ties; +0 and -0 share magnitude 0
  assign beat_take = !beat_nan && (!have_q || (beat_mag < run_min_q));
  assign mrg_min   = beat_take ? beat_mag : run_min_q;
  assign mrg_idx   = beat_take ? cnt_q[IDX_W-1:0] : run_idx_q;
  assign mrg_have  = have_q || beat_take;
  assign mrg_nan   = nan_q || beat_nan;
  assign mrg_neg   = neg_q || beat_neg;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    have_d    = have_q;
    nan_d     = nan_q;
    neg_d     = neg_q;
    res_min_d = res_min_q;
    res_idx_d = res_idx_q;
    res_cnt_d = res_cnt_q;
    res_nan_d = res_nan_q;
    res_neg_d = res_neg_q;

    case (state_q)
      SCAN: begin
        if (accept) begin
          if (close) begin
            res_min_d = mrg_have ? {1'b0, mrg_min} : QNAN;
            res_idx_d = mrg_have ? mrg_idx : '0;
            res_cnt_d = cnt_inc;
            res_nan_d = mrg_nan;
            res_neg_d = mrg_neg;
            cnt_d     = '0;
            run_min_d = '0;
            run_idx_d = '0;
            have_d    = 1'b0;
            nan_d     = 1'b0;
            neg_d     = 1'b0;
            state_d   = DONE;
          end else begin
            cnt_d     = cnt_inc;
            run_min_d = mrg_min;
            run_idx_d = mrg_idx;
            have_d    = mrg_have;
            nan_d     = mrg_nan;
            neg_d     = mrg_neg;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      run_min_q <= '0;
      run_idx_q <= '0;
      have_q    <= 1'b0;
      nan_q     <= 1'b0;
      neg_q     <= 1'b0;
      res_min_q <= '0;
      res_idx_q <= '0;
      res_cnt_q <= '0;
      res_nan_q <= 1'b0;
      res_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_idx_q <= run_idx_d;
      have_q    <= have_d;
      nan_q     <= nan_d;
      neg_q     <= neg_d;
      res_min_q <= res_min_d;
      res_idx_q <= res_idx_d;
      res_cnt_q <= res_cnt_d;
      res_nan_q <= res_nan_d;
      res_neg_q <= res_neg_d;
    end
  end

endmodule

// File: tb/tb_l2_min_select.sv
// tb_l2_min_select: randomized and directed bench for l2_min_select with a
// frame-level reference model (minimum search over the collected beats).
module tb_l2_min_select;

  localparam int N_CAND = 7;
  localparam int IDX_W  = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_dist;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_min;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;
  logic             out_nan;
  logic             out_neg;

  int checks = 0;
  int errors = 0;

  logic [15:0] frame_q[$];
  logic [15:0] stim_q[$];
  logic [15:0] exp_min;
  int          exp_idx;
  int          exp_cnt;
  bit          exp_nan;
  bit          exp_neg;

  l2_min_select #(.N_CAND(N_CAND), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_idx(out_idx),
    .out_count(out_count), .out_nan(out_nan), .out_neg(out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: NaN never wins, magnitude compare, earliest index on ties.
  function automatic void model_close();
    bit          have = 0;
    logic [14:0] best = '0;
    int          bidx = 0;
    exp_nan = 0;
    exp_neg = 0;
    foreach (frame_q[i]) begin
      logic [15:0] d = frame_q[i];
      bit is_nan = (d[14:10] == 5'h1F) && (d[9:0] != 0);
      if (d[15] && d[14:0] != 0) exp_neg = 1;
      if (is_nan) exp_nan = 1;
      else if (!have || d[14:0] < best) begin
        have = 1;
        best = d[14:0];
        bidx = i;
      end
    end
    exp_min = have ? {1'b0, best} : 16'h7E00;
    exp_idx = have ? bidx : 0;
    exp_cnt = frame_q.size();
    frame_q.delete();
  endfunction

  // Called and returns at a negedge. Returns 1 when the beat closed the frame.
  task automatic send(input logic [15:0] d, input bit last, output bit closed);
    int n = 0;
    in_valid = 1'b1;
    in_dist  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame_q.push_back(d);
    closed = last || (frame_q.size() == N_CAND);
    if (closed) model_close();
    @(negedge clk);
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".min"},   32'(out_min), 32'(exp_min));
    chk({tag, ".idx"},   32'(out_idx), 32'(exp_idx));
    chk({tag, ".cnt"},   32'(out_count), 32'(exp_cnt));
    chk({tag, ".nan"},   32'(out_nan), 32'(exp_nan));
    chk({tag, ".neg"},   32'(out_neg), 32'(exp_neg));
  endtask

  task automatic handshake(input int delay);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hs.valid_drop", 32'(out_valid), 32'd0);
  endtask

  // Sends stim_q; last flag on final beat if use_last. Checks result.
  task automatic run_frame(input string tag, input bit use_last, input int delay);
    bit closed = 0;
    for (int i = 0; i < stim_q.size(); i++)
      send(stim_q[i], use_last && (i == stim_q.size() - 1), closed);
    chk({tag, ".closed"}, 32'(closed), 32'd1);
    check_result(tag);
    handshake(delay);
  endtask

  function automatic logic [15:0] rand_dist();
    logic [15:0] d;
    case ($urandom_range(0, 6))
      0: d = {1'b1, 5'($urandom_range(0, 30)), 10'($urandom)};
      1: d = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
      2: d = {1'b0, 5'h1F, 10'h000};
      3: d = {1'($urandom), 15'h0000};
      4: d = 16'h3C00;
      default: d = {1'b0, 5'($urandom_range(0, 30)), 10'($urandom)};
    endcase
    return d;
  endfunction

  initial begin
    bit closed;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_dist   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.min", 32'(out_min), 32'd0);
    chk("rst.idx", 32'(out_idx), 32'd0);
    chk("rst.cnt", 32'(out_count), 32'd0);
    chk("rst.flags", {30'd0, out_nan, out_neg}, 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);

    stim_q = '{16'h4200, 16'h3C00, 16'h4400, 16'h3800, 16'h4500, 16'h3800, 16'h4600};
    run_frame("tie7", 1, 0);
    chk("tie7.idx_lit", 32'(exp_idx), 32'd3);

    stim_q = '{16'h4000, 16'h3E00, 16'h4100};
    run_frame("f3", 1, 0);

    stim_q = '{16'h4400, 16'h4300, 16'h4200, 16'h4100, 16'h4000, 16'h3C00, 16'h3800};
    run_frame("auto7", 0, 1);

    stim_q = '{16'h7E01, 16'h3C00, 16'h7C00, 16'h3C00};
    run_frame("nanmix", 1, 0);

    stim_q = '{16'h7E01, 16'hFC10};
    run_frame("allnan", 1, 0);

    stim_q = '{16'h4000, 16'h4000, 16'h8000, 16'h4000, 16'h0000};
    run_frame("zero", 1, 0);

    stim_q = '{16'h4000, 16'hBC00, 16'h4200};
    run_frame("neg", 1, 0);

    // held result while upstream keeps presenting a beat
    stim_q = '{16'h4000, 16'h3E00, 16'h4100};
    for (int i = 0; i < stim_q.size(); i++) send(stim_q[i], i == 2, closed);
    check_result("hold0");
    in_valid = 1'b1;
    in_dist  = 16'h3C00;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_result("hold");
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold.valid_drop", 32'(out_valid), 32'd0);
    chk("hold.ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame_q.push_back(16'h3C00);
    @(negedge clk);
    send(16'h4400, 1, closed);
    check_result("held_first");
    handshake(0);

    // reset mid-frame
    for (int i = 0; i < 4; i++) send(16'h4000 + 16'(i), 0, closed);
    rst = 1'b1;
    #1;
    chk("mid.rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_q.delete();
    @(negedge clk);
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.outs", {out_min, 4'(out_idx), out_count, 6'd0, out_nan, out_neg}, 32'd0);
    stim_q = '{16'h3C00, 16'h3800};
    run_frame("after_rst", 1, 0);

    for (int f = 0; f < 40; f++) begin
      int len;
      bit use_last;
      use_last = ($urandom_range(0, 3) != 0);
      len = use_last ? $urandom_range(1, N_CAND) : N_CAND;
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(rand_dist());
      run_frame("rnd", use_last, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
